// File: rtl/jk_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jk_divider_ctrl
// Description : Sequencer for a JK-bistable clock divider. It counts modulo a
//               programmable ratio, emits tick/clk_out and checks the bank's Q
//               against the expected count every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_divider_ctrl #(
  parameter int WIDTH         = 4,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_ratio,
  output logic             cfg_err,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_all_ones      = '1;
  localparam logic [WIDTH-1:0] c_one           = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_default_ratio = WIDTH'(DEFAULT_RATIO);

  state_t           r_state;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_s;
  logic             r_p;
  logic             r_clk_out;
  logic             r_cfg_err;

  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_last;
  logic             w_run;
  logic             w_mismatch;
  logic             w_terminal;
  logic             w_xfer;
  logic             w_zero;

  // Bit i toggles when every lower expected bit is 1 (synchronous binary count).
  assign w_toggle[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_toggle
      assign w_toggle[gi] = &r_e[gi-1:0];
    end
  endgenerate

  assign w_last     = r_r - c_one;
  assign w_run      = (r_state == RUN);
  assign w_mismatch = w_run && (q != r_e);
  // A mismatch takes priority, so terminal also implies q == e.
  assign w_terminal = w_run && !w_mismatch && (r_e == w_last);
  assign w_xfer     = cfg_valid && !r_p;
  assign w_zero     = (cfg_ratio == '0);

  always_comb begin
    j = '0;
    k = '0;
    case (r_state)
      CLEAR: k = c_all_ones;
      RUN: begin
        if (w_mismatch || w_terminal) begin
          k = c_all_ones;
        end else begin
          j = w_toggle;
          k = w_toggle;
        end
      end
      default: begin
        j = '0;
        k = '0;
      end
    endcase
  end

  assign tick      = w_terminal;
  assign fault     = w_mismatch;
  assign busy      = (r_state != IDLE);
  assign cfg_ready = !r_p;
  assign cfg_err   = r_cfg_err;
  assign clk_out   = r_clk_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_e       <= '0;
      r_r       <= c_default_ratio;
      r_s       <= '0;
      r_p       <= 1'b0;
      r_clk_out <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && w_zero;

      // Ratio writes go straight to r only while the counter is stopped.
      if (w_xfer && !w_zero) begin
        if (r_state == IDLE) begin
          r_r <= cfg_ratio;
        end else begin
          r_s <= cfg_ratio;
          r_p <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (en) begin
            r_state   <= CLEAR;
            r_clk_out <= 1'b0;
          end
        end
        CLEAR: begin
          r_e <= '0;
          if (r_p) begin
            r_r <= r_s;
            r_p <= 1'b0;
          end
          r_state <= en ? RUN : IDLE;
        end
        RUN: begin
          if (w_mismatch) begin
            r_e     <= '0;
            r_state <= CLEAR;
          end else if (w_terminal) begin
            r_e       <= '0;
            r_clk_out <= ~r_clk_out;
            if (r_p) begin
              r_r <= r_s;
              r_p <= 1'b0;
            end
            r_state <= en ? RUN : CLEAR;
          end else begin
            r_e     <= r_e + c_one;
            r_state <= en ? RUN : CLEAR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_divider_ctrl
// Description : Directed bench for jk_divider_ctrl with a behavioural JK bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_divider_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_ratio;
  logic       cfg_err;
  logic [3:0] q;
  logic [3:0] j;
  logic [3:0] k;
  logic       tick;
  logic       clk_out;
  logic       busy;
  logic       fault;

  logic [3:0] bank_q;
  logic       inj;
  logic [3:0] inj_val;

  int checks   = 0;
  int failures = 0;

  jk_divider_ctrl #(.WIDTH(4), .DEFAULT_RATIO(2)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ratio(cfg_ratio), .cfg_err(cfg_err),
    .q(q), .j(j), .k(k), .tick(tick), .clk_out(clk_out),
    .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bistable bank sharing clk/reset with the sequencer.
  always @(posedge clk or posedge reset) begin
    if (reset) bank_q <= 4'h0;
    else begin
      for (int i = 0; i < 4; i++) begin
        case ({j[i], k[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  assign q = inj ? inj_val : bank_q;

  task automatic do_reset();
    @(negedge clk);
    reset = 1; en = 0; cfg_valid = 0; cfg_ratio = 0; inj = 0; inj_val = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; en = 0; cfg_valid = 0; cfg_ratio = 0; inj = 0; inj_val = 0;
    #1;
    checks++; if (j !== 4'h0 || k !== 4'h0) begin failures++; $display("FAIL reset_jk got j=%h k=%h exp 0 0", j, k); end
    checks++; if (tick !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL reset_tick_fault got %b%b exp 00", tick, fault); end
    checks++; if (clk_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_clkout_busy got %b%b exp 00", clk_out, busy); end
    checks++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg got err=%b rdy=%b exp 0 1", cfg_err, cfg_ready); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || j !== 4'h0 || k !== 4'h0) begin failures++; $display("FAIL reset_idle_hold got busy=%b j=%h k=%h exp 0 0 0", busy, j, k); end
  endtask

  task automatic test_default_ratio();
    logic exp_tick, exp_clk;
    logic [3:0] exp_q;
    int idx;
    do_reset();
    en = 1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        exp_tick = 0; exp_q = 0; exp_clk = 0;
        checks++; if (busy !== 1'b1 || j !== 4'h0 || k !== 4'hf) begin failures++; $display("FAIL default_clear got busy=%b j=%h k=%h exp 1 0 f", busy, j, k); end
      end else begin
        idx = n - 2;
        exp_tick = (idx % 2 == 1);
        exp_q = 4'(idx % 2);
        exp_clk = ((idx / 2) % 2 == 1);
      end
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL default_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
      checks++; if (q !== exp_q) begin failures++; $display("FAIL default_q n=%0d got=%h exp=%h", n, q, exp_q); end
      checks++; if (clk_out !== exp_clk) begin failures++; $display("FAIL default_clkout n=%0d got=%b exp=%b", n, clk_out, exp_clk); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL default_fault n=%0d got=%b exp=0", n, fault); end
    end
    en = 0;
  endtask

  task automatic test_reprogram();
    logic exp_tick, exp_rdy;
    do_reset();
    en = 1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      exp_rdy = (n != 3);
      if (n <= 3) exp_tick = (n == 3);
      else exp_tick = ((n - 4) % 5 == 4);
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL reprog_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
      checks++; if (cfg_ready !== exp_rdy) begin failures++; $display("FAIL reprog_ready n=%0d got=%b exp=%b", n, cfg_ready, exp_rdy); end
      if (n >= 4) begin
        checks++; if (q !== 4'((n - 4) % 5)) begin failures++; $display("FAIL reprog_q n=%0d got=%h exp=%h", n, q, 4'((n - 4) % 5)); end
      end
      if (n == 2) begin cfg_valid = 1; cfg_ratio = 4'd5; end
      if (n == 3) cfg_valid = 0;
    end
    en = 0;
  endtask

  task automatic test_zero_backpressure();
    logic exp_tick, exp_rdy;
    logic [3:0] exp_q;
    do_reset();
    cfg_valid = 1; cfg_ratio = 4'd0;
    @(negedge clk);
    cfg_valid = 0;
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL zero_err_pulse got=%b exp=1", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%b exp=1", cfg_ready); end
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL zero_err_clear got=%b exp=0", cfg_err); end
    en = 1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      exp_tick = (n == 3);
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL zero_ratio_kept n=%0d got=%b exp=%b", n, tick, exp_tick); end
    end

    do_reset();
    cfg_valid = 1; cfg_ratio = 4'd6;
    @(negedge clk);
    cfg_valid = 0;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_direct got=%b exp=1", cfg_ready); end
    en = 1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      exp_rdy = !((n >= 3 && n <= 7) || n == 9 || n == 10);
      exp_tick = (n == 7 || n == 10 || n == 14);
      if (n == 1) exp_q = 0;
      else if (n <= 7) exp_q = 4'(n - 2);
      else if (n <= 10) exp_q = 4'(n - 8);
      else exp_q = 4'(n - 11);
      checks++; if (cfg_ready !== exp_rdy) begin failures++; $display("FAIL bp_ready n=%0d got=%b exp=%b", n, cfg_ready, exp_rdy); end
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL bp_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
      checks++; if (q !== exp_q) begin failures++; $display("FAIL bp_q n=%0d got=%h exp=%h", n, q, exp_q); end
      if (n == 2) begin cfg_valid = 1; cfg_ratio = 4'd3; end
      if (n == 3) cfg_ratio = 4'd4;
      if (n == 9) cfg_valid = 0;
    end
    en = 0;
  endtask

  task automatic test_boundary();
    logic exp_tick;
    logic [3:0] exp_q;
    do_reset();
    cfg_valid = 1; cfg_ratio = 4'd1;
    @(negedge clk);
    cfg_valid = 0;
    en = 1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      exp_tick = (n >= 2);
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL r1_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
      if (n >= 2) begin
        checks++; if (clk_out !== 1'((n - 2) % 2)) begin failures++; $display("FAIL r1_clkout n=%0d got=%b exp=%b", n, clk_out, 1'((n - 2) % 2)); end
        checks++; if (q !== 4'h0 || j !== 4'h0 || k !== 4'hf) begin failures++; $display("FAIL r1_pattern n=%0d got q=%h j=%h k=%h exp 0 0 f", n, q, j, k); end
      end
    end

    do_reset();
    cfg_valid = 1; cfg_ratio = 4'd15;
    @(negedge clk);
    cfg_valid = 0;
    en = 1;
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (n == 1) begin exp_q = 0; exp_tick = 0; end
      else begin exp_q = 4'((n - 2) % 15); exp_tick = ((n - 2) % 15 == 14); end
      checks++; if (q !== exp_q) begin failures++; $display("FAIL r15_q n=%0d got=%h exp=%h", n, q, exp_q); end
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL r15_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
    end
    en = 0;
  endtask

  task automatic test_fault();
    logic exp_tick, exp_fault;
    do_reset();
    cfg_valid = 1; cfg_ratio = 4'd4;
    @(negedge clk);
    cfg_valid = 0;
    en = 1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 3) begin inj = 1; inj_val = 4'd3; end
      if (n == 4) inj = 0;
      #1;
      exp_fault = (n == 3);
      exp_tick = (n >= 5) && ((n - 5) % 4 == 3);
      checks++; if (fault !== exp_fault) begin failures++; $display("FAIL fault_flag n=%0d got=%b exp=%b", n, fault, exp_fault); end
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL fault_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
      if (n == 3 || n == 4) begin
        checks++; if (j !== 4'h0 || k !== 4'hf) begin failures++; $display("FAIL fault_clear n=%0d got j=%h k=%h exp 0 f", n, j, k); end
      end
      if (n == 4) begin
        checks++; if (busy !== 1'b1 || q !== 4'h0) begin failures++; $display("FAIL fault_restart got busy=%b q=%h exp 1 0", busy, q); end
      end
      if (n >= 5) begin
        checks++; if (q !== 4'((n - 5) % 4)) begin failures++; $display("FAIL fault_q n=%0d got=%h exp=%h", n, q, 4'((n - 5) % 4)); end
      end
    end
    en = 0;
  endtask

  task automatic test_stop_and_reset();
    do_reset();
    en = 1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      case (n)
        2: en = 0;
        3: begin
          checks++; if (busy !== 1'b1 || j !== 4'h0 || k !== 4'hf || tick !== 1'b0) begin failures++; $display("FAIL stop_clear got busy=%b j=%h k=%h tick=%b exp 1 0 f 0", busy, j, k, tick); end
        end
        4: begin
          checks++; if (busy !== 1'b0 || q !== 4'h0 || j !== 4'h0 || k !== 4'h0) begin failures++; $display("FAIL stop_idle got busy=%b q=%h j=%h k=%h exp 0 0 0 0", busy, q, j, k); end
          en = 1;
        end
        7: begin
          checks++; if (tick !== 1'b1) begin failures++; $display("FAIL stop_term_tick got=%b exp=1", tick); end
          en = 0;
        end
        8: begin
          checks++; if (busy !== 1'b1 || clk_out !== 1'b1) begin failures++; $display("FAIL stop_term_clear got busy=%b clk_out=%b exp 1 1", busy, clk_out); end
        end
        9: begin
          checks++; if (busy !== 1'b0 || clk_out !== 1'b1) begin failures++; $display("FAIL stop_idle_hold got busy=%b clk_out=%b exp 0 1", busy, clk_out); end
          en = 1;
        end
        10: begin
          checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL restart_clkout got=%b exp=0", clk_out); end
        end
        14: begin
          checks++; if (q !== 4'h1 || clk_out !== 1'b1) begin failures++; $display("FAIL prereset_state got q=%h clk_out=%b exp 1 1", q, clk_out); end
          reset = 1;
          #1;
          checks++; if (tick !== 1'b0 || fault !== 1'b0 || busy !== 1'b0 || clk_out !== 1'b0) begin failures++; $display("FAIL midrun_reset_flags got tick=%b fault=%b busy=%b clk_out=%b exp 0000", tick, fault, busy, clk_out); end
          checks++; if (j !== 4'h0 || k !== 4'h0 || q !== 4'h0) begin failures++; $display("FAIL midrun_reset_bank got j=%h k=%h q=%h exp 0 0 0", j, k, q); end
          checks++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin failures++; $display("FAIL midrun_reset_cfg got rdy=%b err=%b exp 1 0", cfg_ready, cfg_err); end
        end
        default: ;
      endcase
    end
    en = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; en = 0; cfg_valid = 0; cfg_ratio = 0; inj = 0; inj_val = 0;
    test_reset();
    test_default_ratio();
    test_reprogram();
    test_zero_backpressure();
    test_boundary();
    test_fault();
    test_stop_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
